// File: rtl/tcdm_scrub_scheduler.sv
// Round-robin scrub trigger sequencer with saturating ECC error counters and a sticky IRQ.
// Optional access-error statistics are built when TCDM_SCRUB_ECC_STATS_EN is defined.
module tcdm_scrub_scheduler #(
   parameter int NbBanks       = 16,
   parameter int IntervalWidth = 16,
   parameter int CntWidth      = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_i,
   input  logic [IntervalWidth-1:0]   interval_i,
   input  logic [NbBanks-1:0]         bank_mask_i,
   input  logic                       clear_i,
   output logic [NbBanks-1:0]         scrub_trigger_o,
   input  logic [NbBanks-1:0]         scrub_fix_i,
   input  logic [NbBanks-1:0]         scrub_uncorrectable_i,
   input  logic [NbBanks-1:0]         ecc_single_error_i,
   input  logic [NbBanks-1:0]         ecc_multiple_error_i,
   output logic [CntWidth-1:0]        fix_count_o,
   output logic [CntWidth-1:0]        uncorr_count_o,
   output logic [CntWidth-1:0]        single_err_count_o,
   output logic [CntWidth-1:0]        multi_err_count_o,
   output logic [$clog2(NbBanks)-1:0] last_uncorr_bank_o,
   output logic                       irq_o
);

   localparam int PtrW = $clog2(NbBanks);
   localparam int PcW  = $clog2(NbBanks + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TRIG} state_t;

   function automatic logic [PcW-1:0] popcount(input logic [NbBanks-1:0] v);
      logic [PcW-1:0] c;
      c = '0;
      for (int i = 0; i < NbBanks; i++) c = c + PcW'(v[i]);
      return c;
   endfunction

   function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] cnt,
                                                   input logic [PcW-1:0]      pc);
      logic [CntWidth:0] sum;
      sum = {1'b0, cnt} + (CntWidth+1)'(pc);
      return sum[CntWidth] ? '1 : sum[CntWidth-1:0];
   endfunction

   function automatic logic [PtrW-1:0] lowest_idx(input logic [NbBanks-1:0] v);
      logic [PtrW-1:0] idx;
      idx = '0;
      for (int i = NbBanks - 1; i >= 0; i--) if (v[i]) idx = PtrW'(i);
      return idx;
   endfunction

   state_t                   r_state, w_state_nxt;
   logic [IntervalWidth-1:0] r_cnt;
   logic [PtrW-1:0]          r_ptr;
   logic [NbBanks-1:0]       r_trig;
   logic                     w_load, w_dec, w_fire;
   logic [PtrW-1:0]          w_hi_idx, w_wrap_idx, w_sel, w_ptr_nxt;
   logic                     w_hi_found;

   // Bank selection: lowest eligible index at or above ptr, else wrap to lowest eligible.
   always_comb begin
      w_hi_idx   = '0;
      w_wrap_idx = '0;
      w_hi_found = 1'b0;
      for (int i = NbBanks - 1; i >= 0; i--) begin
         if (bank_mask_i[i]) begin
            w_wrap_idx = PtrW'(i);
            if (i >= int'(r_ptr)) begin
               w_hi_idx   = PtrW'(i);
               w_hi_found = 1'b1;
            end
         end
      end
      w_sel     = w_hi_found ? w_hi_idx : w_wrap_idx;
      w_ptr_nxt = (w_sel == PtrW'(NbBanks - 1)) ? '0 : w_sel + PtrW'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_fire      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable_i) begin
               w_state_nxt = S_WAIT;
               w_load      = 1'b1;
            end
         end
         S_WAIT: begin
            if (!enable_i) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt != '0) begin
               w_dec = 1'b1;
            end else begin
               w_state_nxt = S_TRIG;
               w_fire      = |bank_mask_i;
            end
         end
         S_TRIG: begin
            w_load      = 1'b1;
            w_state_nxt = enable_i ? S_WAIT : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_trig  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load)     r_cnt <= interval_i;
         else if (w_dec) r_cnt <= r_cnt - IntervalWidth'(1);
         r_trig <= w_fire ? ({{(NbBanks-1){1'b0}}, 1'b1} << w_sel) : '0;
         if (w_fire) r_ptr <= w_ptr_nxt;
      end
   end

   assign scrub_trigger_o = r_trig;

   logic [NbBanks-1:0]  w_err_vec;
   logic [CntWidth-1:0] r_fix_cnt, r_uncorr_cnt;
   logic [PtrW-1:0]     r_last_bank;
   logic                r_irq;

`ifdef TCDM_SCRUB_ECC_STATS_EN
   logic [CntWidth-1:0] r_single_cnt, r_multi_cnt;

   assign w_err_vec = scrub_uncorrectable_i | ecc_multiple_error_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_single_cnt <= '0;
         r_multi_cnt  <= '0;
      end else begin
         r_single_cnt <= sat_add(r_single_cnt, popcount(ecc_single_error_i));
         r_multi_cnt  <= sat_add(r_multi_cnt, popcount(ecc_multiple_error_i));
      end
   end

   assign single_err_count_o = r_single_cnt;
   assign multi_err_count_o  = r_multi_cnt;
`else
   logic w_unused_ecc;

   assign w_unused_ecc       = ^{ecc_single_error_i, ecc_multiple_error_i};
   assign w_err_vec          = scrub_uncorrectable_i;
   assign single_err_count_o = '0;
   assign multi_err_count_o  = '0;
`endif

   // A new error wins over a same-cycle clear so no event is lost.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fix_cnt    <= '0;
         r_uncorr_cnt <= '0;
         r_last_bank  <= '0;
         r_irq        <= 1'b0;
      end else begin
         if (clear_i) begin
            r_fix_cnt    <= '0;
            r_uncorr_cnt <= '0;
         end else begin
            r_fix_cnt    <= sat_add(r_fix_cnt, popcount(scrub_fix_i));
            r_uncorr_cnt <= sat_add(r_uncorr_cnt, popcount(scrub_uncorrectable_i));
         end
         if (|w_err_vec) begin
            r_irq       <= 1'b1;
            r_last_bank <= lowest_idx(w_err_vec);
         end else if (clear_i) begin
            r_irq <= 1'b0;
         end
      end
   end

   assign fix_count_o        = r_fix_cnt;
   assign uncorr_count_o     = r_uncorr_cnt;
   assign last_uncorr_bank_o = r_last_bank;
   assign irq_o              = r_irq;

endmodule
